// File: rtl/kyber_pkg.sv
// Shared constants and the host-transfer FSM state type for the polynomial RAM.
package kyber_pkg;

  localparam int unsigned KYBER_Q    = 3329;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned COEFF_W    = 12;
  localparam int unsigned LANES      = 8;
  localparam int unsigned WORD_W     = COEFF_W * LANES;
  localparam int unsigned POLY_WORDS = 32;
  localparam int unsigned LANE_W     = $clog2(LANES);
  localparam int unsigned WIDX_W     = $clog2(POLY_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UL_RD,
    UL_WAIT,
    UL_OUT
  } host_state_t;

  typedef logic [LANES-1:0][COEFF_W-1:0] word_t;

endpackage

// File: rtl/poly_ram_mem.sv
// 2**ADDR_W x WORD_W storage: one write port, two registered read ports (old data on collision).
module poly_ram_mem
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WORD_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WORD_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output registers only are reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/poly_ram.sv
// Coefficient RAM behind the NTT core with a host load/unload streaming port.
// Optional coefficient range reduction and sticky ld_err: POLY_RAM_RANGE_CHK_EN.
module poly_ram
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        core_busy,
  input  logic [7:0]  r_data_addr,
  output logic [95:0] r_data,
  input  logic [7:0]  w_data_addr,
  input  logic [95:0] w_data,
  input  logic        w_data_en,
  input  logic        ld_start,
  input  logic [7:0]  ld_base,
  input  logic        ld_valid,
  input  logic [11:0] ld_coeff,
  output logic        ld_ready,
  input  logic        ul_start,
  input  logic [7:0]  ul_base,
  output logic        ul_valid,
  output logic [11:0] ul_coeff,
  input  logic        ul_ready,
  output logic        ul_last,
  output logic        host_busy,
  output logic        done,
  output logic        ld_err
);

  host_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  word_t             pack_q, pack_d;
  word_t             unpack_q, unpack_d;
  logic              done_q, done_d;

  logic              host_we;
  word_t             host_wdata;
  logic [ADDR_W-1:0] host_addr;
  logic [WORD_W-1:0] host_rdata;
  logic [COEFF_W-1:0] coeff_in;

  assign host_addr = base_q + ADDR_W'(word_idx_q);

`ifdef POLY_RAM_RANGE_CHK_EN
  logic coeff_over;
  logic ld_err_q;

  assign coeff_over = ld_coeff >= COEFF_W'(KYBER_Q);
  assign coeff_in   = coeff_over ? ld_coeff - COEFF_W'(KYBER_Q) : ld_coeff;

  always_ff @(posedge clk) begin
    if (rst)
      ld_err_q <= 1'b0;
    else if (state_q == LOAD && ld_valid && !core_busy && coeff_over)
      ld_err_q <= 1'b1;
  end

  assign ld_err = ld_err_q;
`else
  assign coeff_in = ld_coeff;
  assign ld_err   = 1'b0;
`endif

  // Core write always wins the single write port.
  poly_ram_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (w_data_en | host_we),
    .waddr   (w_data_en ? w_data_addr : host_addr),
    .wdata   (w_data_en ? w_data : WORD_W'(host_wdata)),
    .raddr_a (r_data_addr),
    .rdata_a (r_data),
    .raddr_b (host_addr),
    .rdata_b (host_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      word_idx_q <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      unpack_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      unpack_q   <= unpack_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_idx_d = word_idx_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    unpack_d   = unpack_q;
    done_d     = 1'b0;
    host_we    = 1'b0;
    host_wdata = pack_q;
    ld_ready   = 1'b0;
    ul_valid   = 1'b0;
    ul_coeff   = '0;
    ul_last    = 1'b0;
    host_busy  = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (!core_busy) begin
          if (ld_start) begin
            base_d     = ld_base;
            word_idx_d = '0;
            lane_d     = '0;
            state_d    = LOAD;
          end else if (ul_start) begin
            base_d     = ul_base;
            word_idx_d = '0;
            lane_d     = '0;
            state_d    = UL_RD;
          end
        end
      end

      LOAD: begin
        ld_ready = !core_busy;
        if (ld_valid && !core_busy) begin
          pack_d[lane_q] = coeff_in;
          lane_d         = lane_q + LANE_W'(1);
          // Last lane bypasses the pack register straight into the write.
          if (lane_q == LANE_W'(LANES - 1)) begin
            host_we    = 1'b1;
            host_wdata = pack_d;
            word_idx_d = word_idx_q + WIDX_W'(1);
            if (word_idx_q == WIDX_W'(POLY_WORDS - 1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      UL_RD: begin
        if (!core_busy) state_d = UL_WAIT;
      end

      UL_WAIT: begin
        unpack_d = word_t'(host_rdata);
        lane_d   = '0;
        state_d  = UL_OUT;
      end

      UL_OUT: begin
        ul_valid = 1'b1;
        ul_coeff = unpack_q[lane_q];
        ul_last  = (lane_q == LANE_W'(LANES - 1)) &&
                   (word_idx_q == WIDX_W'(POLY_WORDS - 1));
        if (ul_ready) begin
          lane_d = lane_q + LANE_W'(1);
          if (lane_q == LANE_W'(LANES - 1)) begin
            word_idx_d = word_idx_q + WIDX_W'(1);
            if (word_idx_q == WIDX_W'(POLY_WORDS - 1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = UL_RD;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_poly_ram.sv
// Self-checking bench for poly_ram: vector table, directed corner sequences, random transfers vs array model.
module tb_poly_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_busy;
  logic [7:0]  r_data_addr;
  logic [95:0] r_data;
  logic [7:0]  w_data_addr;
  logic [95:0] w_data;
  logic        w_data_en;
  logic        ld_start;
  logic [7:0]  ld_base;
  logic        ld_valid;
  logic [11:0] ld_coeff;
  logic        ld_ready;
  logic        ul_start;
  logic [7:0]  ul_base;
  logic        ul_valid;
  logic [11:0] ul_coeff;
  logic        ul_ready;
  logic        ul_last;
  logic        host_busy;
  logic        done;
  logic        ld_err;

  always #5 clk = ~clk;

  poly_ram dut (
    .clk         (clk),
    .rst         (rst),
    .core_busy   (core_busy),
    .r_data_addr (r_data_addr),
    .r_data      (r_data),
    .w_data_addr (w_data_addr),
    .w_data      (w_data),
    .w_data_en   (w_data_en),
    .ld_start    (ld_start),
    .ld_base     (ld_base),
    .ld_valid    (ld_valid),
    .ld_coeff    (ld_coeff),
    .ld_ready    (ld_ready),
    .ul_start    (ul_start),
    .ul_base     (ul_base),
    .ul_valid    (ul_valid),
    .ul_coeff    (ul_coeff),
    .ul_ready    (ul_ready),
    .ul_last     (ul_last),
    .host_busy   (host_busy),
    .done        (done),
    .ld_err      (ld_err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [95:0] exp;
  } rd_vec_t;

  logic [95:0] model_mem [256];
  logic [11:0] coeffs [256];
  rd_vec_t     vecs [4];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] reduce(input logic [11:0] c);
`ifdef POLY_RAM_RANGE_CHK_EN
    return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
    return c;
`endif
  endfunction

  function automatic logic [95:0] mkword(input int start);
    logic [95:0] w;
    for (int k = 0; k < 8; k++) w[k*12 +: 12] = 12'(start + k);
    return w;
  endfunction

  // Model effect of a completed load of the first nwords words of coeffs.
  task automatic model_load(input logic [7:0] base, input int nwords);
    logic [95:0] wd;
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 8; k++) wd[k*12 +: 12] = reduce(coeffs[w*8 + k]);
      model_mem[8'(int'(base) + w)] = wd;
    end
  endtask

  task automatic check_word(input logic [7:0] addr, input string name);
    r_data_addr = addr;
    tick();
    check(name, r_data, model_mem[addr]);
  endtask

  task automatic verify_poly(input logic [7:0] base);
    for (int w = 0; w < 32; w++) check_word(8'(int'(base) + w), "poly_word");
  endtask

  task automatic random_coeffs(input int maxv);
    for (int i = 0; i < 256; i++) coeffs[i] = 12'($urandom_range(0, maxv));
  endtask

  task automatic load_poly(input logic [7:0] base, input int stall_at, input int stall_len,
                           input int busy_pct, input int exp_cycles);
    int idx, cyc, scnt;
    logic rdy;
    logic [7:0] a2;
    idx = 0; cyc = 0; scnt = 0;
    a2 = base + 8'd2;
    ld_base = base;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("ld_host_busy", 96'(host_busy), 96'(1));
    while (idx < 256 && cyc < 3000) begin
      ld_valid = 1'b1;
      ld_coeff = coeffs[idx];
      if (idx == stall_at && scnt < stall_len) begin
        core_busy = 1'b1;
        r_data_addr = a2;
      end else begin
        core_busy = ($urandom_range(0, 99) < busy_pct);
      end
      #1;
      rdy = ld_ready;
      check("ld_ready", 96'(rdy), 96'(!core_busy));
      if (idx == stall_at && scnt < stall_len) begin
        if (scnt >= 1) check("stall_mem", r_data, model_mem[a2]);
        scnt++;
      end
      tick();
      if (rdy) idx++;
      cyc++;
    end
    ld_valid = 1'b0;
    core_busy = 1'b0;
    check("ld_count", 96'(idx), 96'(256));
    if (exp_cycles >= 0) check("ld_cycles", 96'(cyc), 96'(exp_cycles));
    #1;
    check("ld_done", 96'(done), 96'(1));
    check("ld_idle", 96'(host_busy), 96'(0));
    model_load(base, 32);
    tick();
    check("ld_done_pulse", 96'(done), 96'(0));
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random.
  task automatic unload_poly(input logic [7:0] base, input int ready_mode, input int busy_pct,
                             input int exp_cycles);
    int idx, cyc;
    logic prev_hold;
    logic [11:0] prev_coeff, exp;
    logic [95:0] wv;
    idx = 0; cyc = 0; prev_hold = 1'b0; prev_coeff = '0;
    ul_base = base;
    ul_start = 1'b1;
    tick();
    ul_start = 1'b0;
    while (idx < 256 && cyc < 4000) begin
      case (ready_mode)
        0: ul_ready = 1'b1;
        1: ul_ready = (cyc % 2 == 0);
        default: ul_ready = 1'($urandom_range(0, 1));
      endcase
      core_busy = ($urandom_range(0, 99) < busy_pct);
      #1;
      if (ul_valid) begin
        if (prev_hold) check("ul_hold", 96'(ul_coeff), 96'(prev_coeff));
        wv = model_mem[8'(int'(base) + idx / 8)];
        exp = wv[(idx % 8) * 12 +: 12];
        check("ul_coeff", 96'(ul_coeff), 96'(exp));
        check("ul_last", 96'(ul_last), 96'(idx == 255));
        prev_hold = !ul_ready;
        prev_coeff = ul_coeff;
        if (ul_ready) idx++;
      end else begin
        prev_hold = 1'b0;
      end
      tick();
      cyc++;
    end
    ul_ready = 1'b0;
    core_busy = 1'b0;
    check("ul_count", 96'(idx), 96'(256));
    if (exp_cycles >= 0) check("ul_cycles", 96'(cyc), 96'(exp_cycles));
    #1;
    check("ul_done", 96'(done), 96'(1));
    check("ul_idle", 96'(host_busy), 96'(0));
    tick();
    check("ul_done_pulse", 96'(done), 96'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [95:0] w26;
    rst = 1'b1; core_busy = 1'b0; r_data_addr = '0; w_data_addr = '0; w_data = '0;
    w_data_en = 1'b0; ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_coeff = '0;
    ul_start = 1'b0; ul_base = '0; ul_ready = 1'b0;
    repeat (3) tick();
    check("rst_r_data", r_data, 96'(0));
    check("rst_ld_ready", 96'(ld_ready), 96'(0));
    check("rst_ul_valid", 96'(ul_valid), 96'(0));
    check("rst_ul_coeff", 96'(ul_coeff), 96'(0));
    check("rst_ul_last", 96'(ul_last), 96'(0));
    check("rst_host_busy", 96'(host_busy), 96'(0));
    check("rst_done", 96'(done), 96'(0));
    check("rst_ld_err", 96'(ld_err), 96'(0));
    rst = 1'b0;

    // Fill memory with known random words through the core port.
    for (int a = 0; a < 256; a++) begin
      w_data_en = 1'b1;
      w_data_addr = 8'(a);
      w_data = {$urandom, $urandom, $urandom};
      model_mem[a] = w_data;
      tick();
    end
    w_data_en = 1'b0;
    for (int i = 0; i < 4; i++) check_word(8'($urandom_range(0, 255)), "init_word");

    // Ramp load, then table of core reads.
    for (int i = 0; i < 256; i++) coeffs[i] = 12'(i);
    load_poly(8'd0, -1, 0, 0, 256);
    vecs[0] = '{8'd0,  mkword(0)};
    vecs[1] = '{8'd1,  mkword(8)};
    vecs[2] = '{8'd15, mkword(120)};
    vecs[3] = '{8'd31, mkword(248)};
    for (int i = 0; i < 4; i++) begin
      r_data_addr = vecs[i].addr;
      tick();
      check("tbl_rd", r_data, vecs[i].exp);
    end

    // Core write then unload from it at full rate.
    w_data_en = 1'b1;
    w_data_addr = 8'd64;
    w_data = mkword(100);
    model_mem[64] = mkword(100);
    tick();
    w_data_en = 1'b0;
    unload_poly(8'd64, 0, 0, 320);

    unload_poly(8'd0, 1, 0, -1);

    // Ten-cycle core_busy stall after the 20th coefficient.
    random_coeffs(4095);
    load_poly(8'd100, 20, 10, 0, 266);
    verify_poly(8'd100);

    // Wrap-around load; word 26 must stay untouched.
    w26 = model_mem[26];
    random_coeffs(4095);
    load_poly(8'd250, -1, 0, 0, 256);
    verify_poly(8'd250);
    r_data_addr = 8'd26;
    tick();
    check("wrap_untouched", r_data, w26);

    // Reset in the middle of a load.
    random_coeffs(4095);
    ld_base = 8'd200;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ld_valid = 1'b1;
      ld_coeff = coeffs[i];
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("abort_host_busy", 96'(host_busy), 96'(0));
    check("abort_ld_ready", 96'(ld_ready), 96'(0));
    check("abort_ld_err", 96'(ld_err), 96'(0));
    rst = 1'b0;
    model_load(8'd200, 6);
    for (int w = 200; w < 207; w++) check_word(8'(w), "abort_word");
    random_coeffs(4095);
    load_poly(8'd200, -1, 0, 0, 256);
    verify_poly(8'd200);

    // Random transfers with random core_busy and ul_ready.
    for (int t = 0; t < 4; t++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      random_coeffs(4095);
      load_poly(b, -1, 0, 20, -1);
      unload_poly(8'($urandom_range(0, 255)), 2, 20, -1);
      for (int i = 0; i < 3; i++) check_word(8'($urandom_range(0, 255)), "rand_word");
    end

    // Out-of-range coefficient handling.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    random_coeffs(3328);
    coeffs[0] = 12'd3330;
    load_poly(8'd0, -1, 0, 0, 256);
    check_word(8'd0, "range_word");
    r_data_addr = 8'd0;
    tick();
`ifdef POLY_RAM_RANGE_CHK_EN
    check("range_lane0", 96'(r_data[11:0]), 96'(1));
    check("range_err_set", 96'(ld_err), 96'(1));
    repeat (3) tick();
    check("range_err_sticky", 96'(ld_err), 96'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("range_err_clr", 96'(ld_err), 96'(0));
`else
    check("range_lane0", 96'(r_data[11:0]), 96'(3330));
    check("range_err_off", 96'(ld_err), 96'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
